// File: rtl/instr_encoder.sv
// instr_encoder: packs R-format/addi/slti/beq fields into 32-bit MIPS words
// and streams them, with sequential byte addresses, into an instruction loader.
//
// state   | meaning
// --------+---------------------------------------------------------------
// S_EMPTY | output register empty, ready for a request
// S_VALID | output register holds a word awaiting the loader
// S_FULL  | DEPTH words emitted; only clear_i or rst_i leaves this state
module instr_encoder #(
    parameter int DEPTH = 256
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        clear_i,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic [1:0]  kind_i,
    input  logic [4:0]  rs_i,
    input  logic [4:0]  rt_i,
    input  logic [4:0]  rd_i,
    input  logic [4:0]  shamt_i,
    input  logic [5:0]  funct_i,
    input  logic [15:0] imm_i,
    input  logic [31:0] target_i,
    output logic [31:0] instr_o,
    output logic [31:0] instr_addr_o,
    output logic        instr_valid_o,
    input  logic        instr_ready_i,
    output logic        full_o,
    output logic        err_o
);

    localparam int IW = $clog2(DEPTH) + 1;

    typedef enum logic [1:0] {S_EMPTY, S_VALID, S_FULL} state_t;

    state_t        state;
    logic [IW-1:0] idx;
    logic [32:0]   idx_plus1;
    logic [32:0]   off;
    logic          off_ok;
    logic          at_limit;
    logic          take;
    logic          bad_beq;
    logic          load;
    logic          done;
    logic [31:0]   enc;

    // Branch offset in 33-bit two's complement; in range when bits 32:15 agree.
    assign idx_plus1 = 33'(idx) + 33'd1;
    assign off       = {target_i[31], target_i} - idx_plus1;
    assign off_ok    = (off[32:15] == '0) || (off[32:15] == '1);

    // idx reaching DEPTH means the word in the output register is the last one.
    assign at_limit = (idx == IW'(DEPTH));
    assign take     = req_valid_i & req_ready_o;
    assign bad_beq  = (kind_i == 2'd3) & ~off_ok;
    assign load     = take & ~bad_beq;
    assign done     = (state == S_VALID) & instr_ready_i;

    // Ready depends only on state and the loader's ready, never on req_valid_i.
    always_comb begin
        req_ready_o = 1'b0;
        case (state)
            S_EMPTY: req_ready_o = 1'b1;
            S_VALID: req_ready_o = instr_ready_i & ~at_limit;
            default: req_ready_o = 1'b0;
        endcase
    end

    // Field packing for each instruction kind.
    always_comb begin
        enc = 32'd0;
        case (kind_i)
            2'd0:    enc = {6'b000000, rs_i, rt_i, rd_i, shamt_i, funct_i};
            2'd1:    enc = {6'b001000, rs_i, rt_i, imm_i};
            2'd2:    enc = {6'b001010, rs_i, rt_i, imm_i};
            default: enc = {6'b000100, rs_i, rt_i, off[15:0]};
        endcase
    end

    // Output register, word index, sticky error and state transitions.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state         <= S_EMPTY;
            idx           <= '0;
            instr_o       <= '0;
            instr_addr_o  <= '0;
            instr_valid_o <= 1'b0;
            full_o        <= 1'b0;
            err_o         <= 1'b0;
        end else if (clear_i) begin
            state         <= S_EMPTY;
            idx           <= '0;
            instr_o       <= '0;
            instr_addr_o  <= '0;
            instr_valid_o <= 1'b0;
            full_o        <= 1'b0;
            err_o         <= 1'b0;
        end else begin
            if (take && bad_beq) begin
                err_o <= 1'b1;
            end
            if (load) begin
                instr_o       <= enc;
                instr_addr_o  <= 32'(idx) << 2;
                idx           <= idx + IW'(1);
                state         <= S_VALID;
                instr_valid_o <= 1'b1;
            end else if (done) begin
                instr_valid_o <= 1'b0;
                if (at_limit) begin
                    state  <= S_FULL;
                    full_o <= 1'b1;
                end else begin
                    state <= S_EMPTY;
                end
            end
        end
    end

endmodule

// File: tb/tb_instr_encoder.sv
// Bench for instr_encoder: directed plan steps plus a randomized stream, all
// checked against a transaction-level model (word list, count, flags).
module tb_instr_encoder;

    logic        clk_i = 1'b0;
    logic        rst_i, clear_i, instr_ready_i, req_valid;
    logic        req_valid_b, req_valid_s;
    logic [1:0]  kind_i;
    logic [4:0]  rs_i, rt_i, rd_i, shamt_i;
    logic [5:0]  funct_i;
    logic [15:0] imm_i;
    logic [31:0] target_i;

    logic        b_ready, b_valid, b_full, b_err;
    logic [31:0] b_instr, b_addr;
    logic        s_ready, s_valid, s_full, s_err;
    logic [31:0] s_instr, s_addr;

    bit          sel;
    logic        o_ready, o_valid, o_full, o_err;
    logic [31:0] o_instr, o_addr;

    int n_vec = 0;
    int n_err = 0;

    int          m_depth;
    int          m_count;
    bit          m_has, m_full, m_err;
    logic [31:0] m_word, m_addr;

    always #5 clk_i = ~clk_i;

    assign req_valid_b = req_valid & ~sel;
    assign req_valid_s = req_valid & sel;
    assign o_ready = sel ? s_ready : b_ready;
    assign o_valid = sel ? s_valid : b_valid;
    assign o_full  = sel ? s_full  : b_full;
    assign o_err   = sel ? s_err   : b_err;
    assign o_instr = sel ? s_instr : b_instr;
    assign o_addr  = sel ? s_addr  : b_addr;

    instr_encoder u_big (
        .clk_i(clk_i), .rst_i(rst_i), .clear_i(clear_i),
        .req_valid_i(req_valid_b), .req_ready_o(b_ready), .kind_i(kind_i),
        .rs_i(rs_i), .rt_i(rt_i), .rd_i(rd_i), .shamt_i(shamt_i),
        .funct_i(funct_i), .imm_i(imm_i), .target_i(target_i),
        .instr_o(b_instr), .instr_addr_o(b_addr), .instr_valid_o(b_valid),
        .instr_ready_i(instr_ready_i), .full_o(b_full), .err_o(b_err)
    );

    instr_encoder #(.DEPTH(4)) u_small (
        .clk_i(clk_i), .rst_i(rst_i), .clear_i(clear_i),
        .req_valid_i(req_valid_s), .req_ready_o(s_ready), .kind_i(kind_i),
        .rs_i(rs_i), .rt_i(rt_i), .rd_i(rd_i), .shamt_i(shamt_i),
        .funct_i(funct_i), .imm_i(imm_i), .target_i(target_i),
        .instr_o(s_instr), .instr_addr_o(s_addr), .instr_valid_o(s_valid),
        .instr_ready_i(instr_ready_i), .full_o(s_full), .err_o(s_err)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset(input int depth);
        m_depth = depth;
        m_count = 0;
        m_has   = 1'b0;
        m_full  = 1'b0;
        m_err   = 1'b0;
        m_word  = '0;
        m_addr  = '0;
    endtask

    // Word for the current request as instruction number idx, from field formulas.
    function automatic logic [31:0] ref_encode(input int idx, output bit bad);
        longint t, off;
        logic [31:0] w;
        t   = longint'($signed(target_i));
        off = t - longint'(idx + 1);
        bad = 1'b0;
        case (kind_i)
            2'd0: w = 32'(rs_i) * 32'h20_0000 + 32'(rt_i) * 32'h1_0000
                    + 32'(rd_i) * 32'h800 + 32'(shamt_i) * 32'h40 + 32'(funct_i);
            2'd1: w = 32'd8 * 32'h400_0000 + 32'(rs_i) * 32'h20_0000
                    + 32'(rt_i) * 32'h1_0000 + 32'(imm_i);
            2'd2: w = 32'd10 * 32'h400_0000 + 32'(rs_i) * 32'h20_0000
                    + 32'(rt_i) * 32'h1_0000 + 32'(imm_i);
            default: begin
                bad = (off < -32768) || (off > 32767);
                w = 32'd4 * 32'h400_0000 + 32'(rs_i) * 32'h20_0000
                    + 32'(rt_i) * 32'h1_0000 + 32'(off & 64'hFFFF);
            end
        endcase
        return w;
    endfunction

    function automatic bit pred_ready();
        if (m_full) return 1'b0;
        if (!m_has) return 1'b1;
        return instr_ready_i && (m_count < m_depth);
    endfunction

    // One clock: check ready before the edge, advance the model, check outputs after.
    task automatic cycle();
        bit pr, done, take, bad;
        logic [31:0] w;
        #1;
        pr = pred_ready();
        check("req_ready", 32'(o_ready), 32'(pr));
        done = m_has && instr_ready_i;
        take = req_valid && pr;
        w    = ref_encode(m_count, bad);
        @(posedge clk_i);
        if (clear_i) begin
            model_reset(m_depth);
        end else begin
            if (take && bad) m_err = 1'b1;
            if (take && !bad) begin
                m_word = w;
                m_addr = 32'(m_count * 4);
                m_count++;
                m_has = 1'b1;
            end else if (done) begin
                m_has = 1'b0;
                if (m_count == m_depth) m_full = 1'b1;
            end
        end
        #1;
        check("instr_valid", 32'(o_valid), 32'(m_has));
        check("full", 32'(o_full), 32'(m_full));
        check("err", 32'(o_err), 32'(m_err));
        if (m_has) begin
            check("instr", o_instr, m_word);
            check("instr_addr", o_addr, m_addr);
        end
    endtask

    task automatic do_clear();
        clear_i   = 1'b1;
        req_valid = 1'b0;
        cycle();
        clear_i = 1'b0;
    endtask

    task automatic set_req(input logic [1:0] k, input logic [4:0] rs, input logic [4:0] rt,
                           input logic [15:0] imm, input logic [31:0] tgt);
        kind_i = k; rs_i = rs; rt_i = rt; imm_i = imm; target_i = tgt;
        req_valid = 1'b1;
    endtask

    initial begin
        sel = 1'b0;
        rst_i = 1'b1; clear_i = 1'b0; instr_ready_i = 1'b0; req_valid = 1'b0;
        kind_i = '0; rs_i = '0; rt_i = '0; rd_i = '0; shamt_i = '0; funct_i = '0;
        imm_i = '0; target_i = '0;
        #12;
        rst_i = 1'b0;
        #1;
        check("rst_valid", 32'(o_valid), 32'd0);
        check("rst_instr", o_instr, 32'd0);
        check("rst_addr", o_addr, 32'd0);
        check("rst_full", 32'(o_full), 32'd0);
        check("rst_err", 32'(o_err), 32'd0);
        check("rst_ready", 32'(o_ready), 32'd1);
        model_reset(256);

        // R-format, then idle back to EMPTY
        instr_ready_i = 1'b1;
        kind_i = 2'd0; rs_i = 5'd1; rt_i = 5'd2; rd_i = 5'd3; shamt_i = 5'd0; funct_i = 6'h20;
        req_valid = 1'b1;
        cycle();
        check("r_word", o_instr, 32'h00221820);
        check("r_addr", o_addr, 32'd0);
        req_valid = 1'b0;
        cycle();
        check("r_empty", 32'(o_valid), 32'd0);
        do_clear();

        // addi, slti, beq back to back
        set_req(2'd1, 5'd0, 5'd4, 16'd5, 32'd0);
        cycle();
        check("addi_word", o_instr, 32'h20040005);
        check("addi_addr", o_addr, 32'd0);
        set_req(2'd2, 5'd4, 5'd5, 16'h000A, 32'd0);
        cycle();
        check("slti_word", o_instr, 32'h2885000A);
        check("slti_addr", o_addr, 32'd4);
        set_req(2'd3, 5'd1, 5'd2, 16'd0, 32'd0);
        cycle();
        check("beq_word", o_instr, 32'h1022FFFD);
        check("beq_addr", o_addr, 32'd8);
        req_valid = 1'b0;
        cycle();
        do_clear();

        // Out-of-range beq is consumed, not emitted, sets err
        set_req(2'd3, 5'd1, 5'd2, 16'd0, 32'h00010000);
        cycle();
        check("bad_err", 32'(o_err), 32'd1);
        check("bad_valid", 32'(o_valid), 32'd0);
        set_req(2'd1, 5'd3, 5'd3, 16'd7, 32'd0);
        cycle();
        check("after_bad_addr", o_addr, 32'd0);
        req_valid = 1'b0;
        cycle();
        do_clear();
        check("clear_err", 32'(o_err), 32'd0);

        // Offset boundaries: +32767 and -32768 accepted, -32769 rejected
        set_req(2'd3, 5'd1, 5'd2, 16'd0, 32'd32768);
        cycle();
        check("off_max", o_instr, 32'h10227FFF);
        set_req(2'd3, 5'd1, 5'd2, 16'd0, -32'sd32766);
        cycle();
        check("off_min", o_instr, 32'h10228000);
        set_req(2'd3, 5'd1, 5'd2, 16'd0, -32'sd32766);
        cycle();
        check("off_under_err", 32'(o_err), 32'd1);
        req_valid = 1'b0;
        cycle();
        do_clear();

        // Backpressure for three cycles with a request waiting
        set_req(2'd1, 5'd9, 5'd10, 16'h1234, 32'd0);
        cycle();
        instr_ready_i = 1'b0;
        set_req(2'd2, 5'd11, 5'd12, 16'h5678, 32'd0);
        for (int i = 0; i < 3; i++) begin
            cycle();
            check("bp_hold_word", o_instr, 32'h212A1234);
            check("bp_hold_addr", o_addr, 32'd0);
            check("bp_ready", 32'(o_ready), 32'd0);
        end
        instr_ready_i = 1'b1;
        cycle();
        check("bp_next_word", o_instr, 32'h296C5678);
        check("bp_next_addr", o_addr, 32'd4);
        req_valid = 1'b0;
        cycle();
        do_clear();

        // Randomized stream with occasional clears
        for (int i = 0; i < 700; i++) begin
            kind_i  = 2'($urandom_range(0, 3));
            rs_i    = 5'($urandom); rt_i = 5'($urandom); rd_i = 5'($urandom);
            shamt_i = 5'($urandom); funct_i = 6'($urandom); imm_i = 16'($urandom);
            if ($urandom_range(0, 7) == 0) target_i = $urandom;
            else target_i = 32'(m_count + int'($urandom_range(0, 70000)) - 35000);
            req_valid     = ($urandom_range(0, 3) != 0);
            instr_ready_i = ($urandom_range(0, 3) != 0);
            clear_i       = ($urandom_range(0, 59) == 0);
            cycle();
        end
        clear_i = 1'b0;

        // DEPTH=4 instance: fill, FULL, clear restart, async reset
        sel = 1'b1;
        model_reset(4);
        instr_ready_i = 1'b1;
        do_clear();
        for (int i = 0; i < 5; i++) begin
            set_req(2'd1, 5'(i), 5'(i + 1), 16'(i), 32'd0);
            cycle();
        end
        req_valid = 1'b0;
        cycle();
        check("small_full", 32'(o_full), 32'd1);
        check("small_ready", 32'(o_ready), 32'd0);
        do_clear();
        set_req(2'd2, 5'd1, 5'd1, 16'd1, 32'd0);
        cycle();
        check("small_restart_addr", o_addr, 32'd0);
        instr_ready_i = 1'b0;
        req_valid = 1'b0;
        rst_i = 1'b1;
        #1;
        check("arst_valid", 32'(o_valid), 32'd0);
        check("arst_instr", o_instr, 32'd0);
        check("arst_addr", o_addr, 32'd0);
        check("arst_ready", 32'(o_ready), 32'd1);
        #10;
        rst_i = 1'b0;
        model_reset(4);
        cycle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/instr_encoder.md
# instr_encoder

Packs MIPS-subset instruction fields into 32-bit machine words and streams them, with sequential word addresses, into the lab CPU's instruction memory loader. It is the producing end of the opcode interface the CPU's control decoder consumes. It covers R-format, addi, slti and beq. It computes beq branch offsets from absolute targets, and it is the bench-side and boot-side source of test programs.

## Interface
- DEPTH, default 256: capacity of the instruction memory in words; the block emits at most DEPTH words per program.
- clk_i  in  1  clock; all state changes on the rising edge.
- rst_i  in  1  reset, asynchronous, active-high.
- clear_i  in  1  synchronous program restart. It empties the output register, zeroes the word count and clears err_o.
- req_valid_i  in  1  an instruction request is present.
- req_ready_o  out  1  the block accepts the request this cycle.
- kind_i  in  2  instruction kind: 0 = R-format, 1 = addi, 2 = slti, 3 = beq.
- rs_i, rt_i, rd_i, shamt_i  in  5 each  register and shift fields.
- funct_i  in  6  R-format function field.
- imm_i  in  16  immediate for addi and slti.
- target_i  in  32  beq target as an absolute word index, two's complement.
- instr_o  out  32  encoded word.
- instr_addr_o  out  32  byte address of instr_o, equal to word index × 4.
- instr_valid_o  out  1  instr_o and instr_addr_o are valid.
- instr_ready_i  in  1  the downstream loader takes the word.
- full_o  out  1  DEPTH words have been emitted.
- err_o  out  1  sticky flag: a beq offset was out of range.

## Operation
Encoding, where op is bits 31:26:
- R-format: {000000, rs, rt, rd, shamt, funct}.
- addi: {001000, rs, rt, imm}.
- slti: {001010, rs, rt, imm}.
- beq: {000100, rs, rt, off[15:0]}.
  - off = target_i − (idx + 1), computed in 33-bit signed arithmetic.
  - idx is the word index assigned to this instruction.
  - off must lie in the range −32768..32767.
  - An out-of-range beq is consumed with req_ready_o=1 and is not emitted. It sets err_o and does not advance idx.
- Fields are taken verbatim with no masking; widths are fixed by the port widths.

State machine with states EMPTY, VALID and FULL:
- EMPTY: output register empty, instr_valid_o=0, req_ready_o=1.
  - An accepted valid request loads the output register and moves to VALID.
- VALID: instr_valid_o=1, req_ready_o=instr_ready_i.
  - instr_ready_i=1 with req_valid_i=1: the handshake completes and the new word loads in the same cycle. The state stays VALID, giving back-to-back throughput of 1 word per cycle.
  - instr_ready_i=1 with req_valid_i=0: go to EMPTY.
  - Any handshake that completes word index DEPTH−1: go to FULL and do not accept a new word in that cycle.
- FULL: full_o=1, req_ready_o=0, instr_valid_o=0. Only clear_i or rst_i leaves this state.

Word index counter:
- Width clog2(DEPTH)+1 bits.
- Increments on each load of a valid encoded word.
- instr_addr_o = {idx_of_word, 2'b00}, zero-extended to 32 bits.

clear_i:
- Takes priority over any handshake in the same cycle.
- Next state is EMPTY, and idx and err_o are set to 0.
- A word pending in the output register is discarded.

Reset values:
- state EMPTY.
- instr_o = 0, instr_addr_o = 0.
- instr_valid_o = 0, full_o = 0, err_o = 0.
- idx = 0.
- req_ready_o = 1 once the state is EMPTY.

## Timing
- Latency is 1 cycle: a request accepted at edge N appears on instr_o with instr_valid_o=1 after edge N.
- instr_o and instr_addr_o are registered and stay stable while instr_valid_o=1 and instr_ready_i=0.
- req_ready_o is combinational from the state and instr_ready_i only. It has no path from req_valid_i.
- The downstream loader must not make instr_ready_i depend on req_valid_i.
- err_o rises on the edge following the rejected beq.
- Asserting rst_i mid-stream forces all outputs to their reset values immediately, with no clock needed.

## Test plan
- Reset, then one R-format request (rs=1, rt=2, rd=3, shamt=0, funct=0x20) with instr_ready_i=1:
  - instr_o=0x00221820 and instr_addr_o=0 one cycle later.
  - state returns to EMPTY.
- Back-to-back addi (rs=0, rt=4, imm=5) then slti (rs=4, rt=5, imm=10) with ready held high:
  - words 0x20040005 at address 0 and 0x2885000A at address 4 on consecutive cycles.
- beq as word index 2 (rs=1, rt=2, target=0):
  - off=−3, giving instr_o=0x1022FFFD at instr_addr_o=8.
- beq with target=0x00010000 at idx 0:
  - request consumed, no word emitted, err_o=1, next word still at address 0.
  - clear_i then returns err_o to 0.
- Backpressure: hold instr_ready_i=0 for 3 cycles while VALID:
  - instr_o and instr_addr_o stay stable.
  - req_ready_o=0.
  - no request is lost.
- DEPTH=4 build, 5 requests with ready high:
  - 4 words emitted, full_o=1, req_ready_o=0.
  - clear_i restarts at address 0.
  - rst_i asserted mid-VALID drops instr_valid_o asynchronously.
